// File: rtl/store_align_buffer_pkg.sv
// Shared store/load encodings: op codes and byte-enable patterns used by the
// store alignment path and the load extender.
package store_align_buffer_pkg;

  localparam logic [2:0] OP_SW = 3'b000;
  localparam logic [2:0] OP_SH = 3'b001;
  localparam logic [2:0] OP_SB = 3'b010;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

endpackage

// File: rtl/store_align_buffer_store_align.sv
// Combinational store aligner: maps (addr[1:0], data, op) to byte enables and
// lane-replicated write data; illegal ops are reported as misaligned too.
module store_align
  import store_align_buffer_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  input  logic [2:0]  op,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);

  // Decode op into lane pattern and alignment legality.
  always_comb begin
    be         = 4'b0000;
    wdata      = 32'h0000_0000;
    misaligned = 1'b0;
    case (op)
      OP_SW: begin
        be         = BE_WORD;
        wdata      = data;
        misaligned = (addr_lo != 2'b00);
      end
      OP_SH: begin
        be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata      = {2{data[15:0]}};
        misaligned = addr_lo[0];
      end
      OP_SB: begin
        be         = 4'b0001 << addr_lo;
        wdata      = {4{data[7:0]}};
        misaligned = 1'b0;
      end
      default: begin
        be         = 4'b0000;
        wdata      = 32'h0000_0000;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_align_buffer.sv
// Store buffer: aligns MEM-stage stores, queues them in a small FIFO and
// issues word-aligned writes with byte enables over a valid/ready port.
module store_align_buffer
  import store_align_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [31:0]   in_data,
  input  logic [2:0]    in_op,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] m_addr,
  output logic [3:0]    m_be,
  output logic [31:0]   m_wdata,
  output logic          busy,
  output logic          store_err,
  output logic [AW-1:0] err_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-3:0] addr_mem_q [DEPTH];
  logic [AW-3:0] addr_mem_d [DEPTH];
  logic [3:0]    be_mem_q [DEPTH];
  logic [3:0]    be_mem_d [DEPTH];
  logic [31:0]   wdata_mem_q [DEPTH];
  logic [31:0]   wdata_mem_d [DEPTH];
  logic          store_err_q, store_err_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_bad;
  logic        full, empty, accept, push, pop;

  store_align u_align (
    .addr_lo    (in_addr[1:0]),
    .data       (in_data),
    .op         (in_op),
    .be         (al_be),
    .wdata      (al_wdata),
    .misaligned (al_bad)
  );

  // No same-cycle slot reuse: a full buffer refuses input even while popping.
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == {CW{1'b0}});
  assign accept = in_valid && !full;
  assign push   = accept && !al_bad;
  assign pop    = !empty && m_ready;

  // Next-state for FIFO storage, pointers, count and error reporting.
  always_comb begin
    addr_mem_d  = addr_mem_q;
    be_mem_d    = be_mem_q;
    wdata_mem_d = wdata_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    store_err_d = accept && al_bad;
    err_addr_d  = err_addr_q;
    if (push) begin
      addr_mem_d[wr_ptr_q]  = in_addr[AW-1:2];
      be_mem_d[wr_ptr_q]    = al_be;
      wdata_mem_d[wr_ptr_q] = al_wdata;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (accept && al_bad) begin
      err_addr_d = in_addr;
    end else begin
      err_addr_d = err_addr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops every pending entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      store_err_q <= 1'b0;
      err_addr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i]  <= '0;
        be_mem_q[i]    <= 4'b0000;
        wdata_mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      store_err_q <= store_err_d;
      err_addr_q  <= err_addr_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i]  <= addr_mem_d[i];
        be_mem_q[i]    <= be_mem_d[i];
        wdata_mem_q[i] <= wdata_mem_d[i];
      end
    end
  end

  assign in_ready  = !full;
  assign m_valid   = !empty;
  assign busy      = !empty;
  assign m_addr    = empty ? {AW{1'b0}} : {addr_mem_q[rd_ptr_q], 2'b00};
  assign m_be      = empty ? 4'b0000 : be_mem_q[rd_ptr_q];
  assign m_wdata   = empty ? 32'h0000_0000 : wdata_mem_q[rd_ptr_q];
  assign store_err = store_err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_store_align_buffer.sv
// Self-checking bench: directed steps plus a random stream, compared each
// cycle against a queue-based reference of the store buffer.
module tb_store_align_buffer;

  localparam int DEPTH = 2;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [31:0]   in_data;
  logic [2:0]    in_op;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_be;
  logic [31:0]   m_wdata;
  logic          busy;
  logic          store_err;
  logic [AW-1:0] err_addr;

  always #5 clk = ~clk;

  store_align_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_op(in_op),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_be(m_be), .m_wdata(m_wdata),
    .busy(busy), .store_err(store_err), .err_addr(err_addr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t         q[$];
  logic        err_m;
  logic [31:0] err_addr_m;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rule: a store of 'size' bytes covers lanes [a%4, a%4+size),
  // and lane i carries byte (i mod size) of the right-justified data.
  function automatic bit model_store(input logic [31:0] a, input logic [31:0] d,
                                     input logic [2:0] op, output wr_t w);
    int size;
    int off;
    size = (op == 3'd0) ? 4 : (op == 3'd1) ? 2 : 1;
    off  = int'(a % 4);
    w.addr = a - (a % 4);
    w.be   = 4'b0000;
    w.data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) w.be[i] = 1'b1;
      w.data[8*i +: 8] = d[8*(i % size) +: 8];
    end
    return (op <= 3'd2) && (off % size == 0);
  endfunction

  task automatic cycle(input logic rst, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] op, input logic mr);
    wr_t w;
    bit  legal;
    bit  rdy;
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
    chk("m_valid", {31'b0, m_valid}, {31'b0, q.size() > 0});
    chk("busy", {31'b0, busy}, {31'b0, q.size() > 0});
    chk("m_addr", m_addr, (q.size() > 0) ? q[0].addr : 32'h0);
    chk("m_be", {28'b0, m_be}, (q.size() > 0) ? {28'b0, q[0].be} : 32'h0);
    chk("m_wdata", m_wdata, (q.size() > 0) ? q[0].data : 32'h0);
    chk("store_err", {31'b0, store_err}, {31'b0, err_m});
    chk("err_addr", err_addr, err_addr_m);
    reset    = rst;
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_op    = op;
    m_ready  = mr;
    @(posedge clk);
    if (rst) begin
      q.delete();
      err_m      = 1'b0;
      err_addr_m = 32'h0;
    end else begin
      rdy   = (q.size() < DEPTH);
      legal = model_store(a, d, op, w);
      if (q.size() > 0 && mr) void'(q.pop_front());
      err_m = v && rdy && !legal;
      if (v && rdy && legal) q.push_back(w);
      if (err_m) err_addr_m = a;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; in_op = 3'd0; m_ready = 1'b0;
    err_m = 1'b0; err_addr_m = 32'h0;
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);

    // sb to byte lane 3, popped immediately
    cycle(1'b0, 1'b1, 32'h0000_1003, 32'h0000_00A5, 3'd2, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

    // sh + sw fill the buffer, then drain in order
    cycle(1'b0, 1'b1, 32'h0000_2002, 32'h1234_BEEF, 3'd1, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 3'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

    // misaligned sw and illegal op
    cycle(1'b0, 1'b1, 32'h0000_3001, 32'h1111_1111, 3'd0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_4000, 32'h2222_2222, 3'b101, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

    // full buffer with pop and push offered together, then retry
    cycle(1'b0, 1'b1, 32'h0000_5000, 32'hAAAA_0001, 3'd0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_5004, 32'hAAAA_0002, 3'd0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_5008, 32'hAAAA_0003, 3'd0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_5008, 32'hAAAA_0003, 3'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

    // reset with two pending entries
    cycle(1'b0, 1'b1, 32'h0000_6000, 32'h6666_0000, 3'd0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_6006, 32'h0000_7777, 3'd1, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

    // continuous sb stream across all lanes, pointers wrap
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b1, 32'(i), 32'(8'h30 + i), 3'd2, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [2:0] op_r;
      op_r = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), $urandom(),
            $urandom(), op_r, ($urandom_range(0, 2) != 0));
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
